// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor: diff = a - b - bin.
// The lower half resolves in S1, the upper half plus the status flags in S2.
module cla_sub_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int HW = WIDTH / 2;
    localparam int NG = HW / 4;

    // Returns {group generate, group propagate, 4-bit difference}.
    function automatic logic [5:0] grp_sub(input logic [3:0] ga, input logic [3:0] gb,
                                           input logic bi);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] bw;
        logic       gg;
        logic       gp;
        g  = ~ga & gb;
        p  = ~(ga ^ gb);
        bw[0] = bi;
        bw[1] = g[0] | (p[0] & bi);
        bw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        bw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp = &p;
        return {gg, gp, ga ^ gb ^ bw};
    endfunction

    // Second-level lookahead across the groups of one half; returns {borrow out, diff}.
    function automatic logic [HW:0] half_sub(input logic [HW-1:0] ha, input logic [HW-1:0] hb,
                                             input logic bi);
        logic [NG:0]   bg;
        logic [HW-1:0] d;
        logic [5:0]    r;
        bg    = '0;
        d     = '0;
        bg[0] = bi;
        for (int k = 0; k < NG; k++) begin
            r            = grp_sub(ha[4*k +: 4], hb[4*k +: 4], bg[k]);
            d[4*k +: 4]  = r[3:0];
            bg[k+1]      = r[5] | (r[4] & bg[k]);
        end
        return {bg[NG], d};
    endfunction

    logic          vld_p1_q;
    logic [HW-1:0] lo_diff_p1_q;
    logic          bmid_p1_q;
    logic [HW-1:0] a_hi_p1_q;
    logic [HW-1:0] b_hi_p1_q;

    logic             vld_p2_q;
    logic [WIDTH-1:0] diff_p2_q;
    logic             bout_p2_q;
    logic             ovf_p2_q;
    logic             zero_p2_q;

    logic             out_adv;
    logic             accept;
    logic             s2_load;
    logic [HW:0]      lo_res;
    logic [HW:0]      hi_res;
    logic [WIDTH-1:0] diff_d;
    logic             ovf_d;

    assign out_adv  = ~vld_p2_q | out_ready;
    assign in_ready = ~vld_p1_q | out_adv;
    assign accept   = in_valid & in_ready;
    assign s2_load  = vld_p1_q & out_adv;

    always_comb begin
        lo_res = half_sub(a[HW-1:0], b[HW-1:0], bin);
        hi_res = half_sub(a_hi_p1_q, b_hi_p1_q, bmid_p1_q);
        diff_d = {hi_res[HW-1:0], lo_diff_p1_q};
        ovf_d  = (a_hi_p1_q[HW-1] ^ b_hi_p1_q[HW-1]) & (hi_res[HW-1] ^ a_hi_p1_q[HW-1]);
    end

    // Stage 1: lower half resolved, upper operands carried forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q     <= 1'b0;
            lo_diff_p1_q <= '0;
            bmid_p1_q    <= 1'b0;
            a_hi_p1_q    <= '0;
            b_hi_p1_q    <= '0;
        end else begin
            if (accept) begin
                vld_p1_q     <= 1'b1;
                lo_diff_p1_q <= lo_res[HW-1:0];
                bmid_p1_q    <= lo_res[HW];
                a_hi_p1_q    <= a[WIDTH-1:HW];
                b_hi_p1_q    <= b[WIDTH-1:HW];
            end else if (s2_load) begin
                vld_p1_q <= 1'b0;
            end
        end
    end

    // Stage 2: upper half and flags into the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q  <= 1'b0;
            diff_p2_q <= '0;
            bout_p2_q <= 1'b0;
            ovf_p2_q  <= 1'b0;
            zero_p2_q <= 1'b0;
        end else begin
            if (s2_load) begin
                vld_p2_q  <= 1'b1;
                diff_p2_q <= diff_d;
                bout_p2_q <= hi_res[HW];
                ovf_p2_q  <= ovf_d;
                zero_p2_q <= (diff_d == '0);
            end else if (out_ready) begin
                vld_p2_q <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign diff      = diff_p2_q;
    assign bout      = bout_p2_q;
    assign ovf       = ovf_p2_q;
    assign zero      = zero_p2_q;
endmodule

// File: tb/tb_cla_sub_pipe.sv
// Bench for cla_sub_pipe: fixed vectors, backpressure, mid-stream reset and a
// randomized stream compared in order against an arithmetic reference queue.
module tb_cla_sub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    cla_sub_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          ntests = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    logic        held   = 1'b0;
    logic [18:0] prev_out;
    logic        last_acc;
    int          n_cons = 0;
    int          blocked = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic exp_t ref_sub(input logic [15:0] ra, input logic [15:0] rb,
                                     input logic rbin);
        exp_t e;
        int   ua, ub, sa, sb, sr;
        ua   = int'(ra);
        ub   = int'(rb);
        sa   = int'($signed(ra));
        sb   = int'($signed(rb));
        sr   = sa - sb - int'(rbin);
        e.d  = 16'((ua - ub - int'(rbin)) & 32'hFFFF);
        e.bo = (ua < ub + int'(rbin));
        e.ov = (sr < -32768) || (sr > 32767);
        e.z  = (e.d == 16'h0000);
        e.t  = 0;
        return e;
    endfunction

    // One clock cycle: drive inputs, check against the reference, then advance.
    task automatic cyc_step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                            input logic ibin, input logic ordy);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !(q.size() == 2 && !ordy)});
        chk("out_valid", {31'd0, out_valid},
            {31'd0, (q.size() > 0) && (cyc - (q.size() > 0 ? q[0].t : cyc) >= 2)});
        if (held)
            chk("stall_hold", {13'd0, diff, bout, ovf, zero}, {13'd0, prev_out});
        if (!in_ready) blocked++;
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                chk("diff", {16'd0, diff}, {16'd0, q[0].d});
                chk("flags", {29'd0, bout, ovf, zero}, {29'd0, q[0].bo, q[0].ov, q[0].z});
                void'(q.pop_front());
                n_cons++;
            end
        end
        last_acc = iv && in_ready;
        if (last_acc) begin
            e   = ref_sub(ia, ib, ibin);
            e.t = cyc;
            q.push_back(e);
        end
        held     = out_valid && !ordy;
        prev_out = {diff, bout, ovf, zero};
        @(posedge clk);
        cyc++;
        #1;
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'h0100, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_diff", {16'd0, diff}, 32'd0);
        chk("rst_flags", {29'd0, bout, ovf, zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed vectors: one transaction each, result checked two edges later.
        for (int i = 0; i < 9; i++) begin
            cyc_step(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b1);
            cyc_step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_diff", {16'd0, diff}, {16'd0, tbl[i].d});
            chk("vec_flags", {29'd0, bout, ovf, zero}, {29'd0, tbl[i].bo, tbl[i].ov, tbl[i].z});
        end
        cyc_step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Backpressure: five back-to-back transactions, consumer stalled on cycles 2..4.
        begin
            int sent = 0;
            int c    = 0;
            n_cons  = 0;
            blocked = 0;
            while ((sent < 5 || q.size() > 0) && c < 40) begin
                cyc_step(sent < 5, 16'(sent + 10), 16'(sent), 1'b0, !(c >= 2 && c <= 4));
                if (last_acc) sent++;
                c++;
            end
            chk("bp_consumed", n_cons, 32'd5);
            chk("bp_blocked", {31'd0, blocked > 0}, 32'd1);
        end

        // Mid-stream reset with both stages occupied.
        cyc_step(1'b1, 16'h1111, 16'h0001, 1'b0, 1'b0);
        cyc_step(1'b1, 16'h2222, 16'h0002, 1'b0, 1'b0);
        cyc_step(1'b1, 16'h3333, 16'h0003, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_diff", {16'd0, diff}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        held = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); cyc++; #1;
        cyc_step(1'b1, 16'h0040, 16'h0004, 1'b0, 1'b1);
        cyc_step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_diff", {16'd0, diff}, 32'h003C);
        cyc_step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Randomized stream with random handshakes.
        begin
            int acc = 0;
            logic [15:0] ra, rb;
            for (int c = 0; c < 6000 && acc < 1000; c++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                case ($urandom_range(0, 7))
                    0: ra = 16'h0000;
                    1: rb = 16'hFFFF;
                    2: ra = 16'h8000;
                    3: rb = ra;
                    default: ;
                endcase
                cyc_step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 3) != 0);
                if (last_acc) acc++;
            end
            chk("rand_accepts", acc, 32'd1000);
        end

        for (int c = 0; c < 10 && q.size() > 0; c++)
            cyc_step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("drain_empty", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
